// File: rtl/hyperbus_addr_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hyperbus_addr_decode_stage                                   |
// | Description : Decodes global transactions into one-hot chip select plus    |
// |               chip-local address, buffered in a 2-entry FIFO.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package hyperbus_addr_decode_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;
endpackage

module hyperbus_addr_decode_stage #(
  parameter int unsigned NUM_CHIPS     = 2,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned LEN_WIDTH     = 16,
  parameter int unsigned ERR_CNT_WIDTH = 8,
  parameter type         RULE_T        = hyperbus_addr_decode_pkg::addr_rule_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  RULE_T                    chip_rules_i [NUM_CHIPS],
  input  logic [4:0]               addr_mask_msb_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ADDR_WIDTH-1:0]    in_addr_i,
  input  logic                     in_write_i,
  input  logic [LEN_WIDTH-1:0]     in_len_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NUM_CHIPS-1:0]     out_cs_o,
  output logic [ADDR_WIDTH-1:0]    out_addr_o,
  output logic                     out_write_o,
  output logic [LEN_WIDTH-1:0]     out_len_o,
  output logic                     out_decerr_o,
  input  logic                     phy_busy_i,
  output logic                     trans_active_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  input  logic                     err_clr_i
);

  typedef struct packed {
    logic [NUM_CHIPS-1:0]  cs;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [LEN_WIDTH-1:0]  len;
    logic                  decerr;
  } entry_t;

  localparam logic [ERR_CNT_WIDTH-1:0] c_err_max = {ERR_CNT_WIDTH{1'b1}};

  logic [ADDR_WIDTH-1:0] w_start   [NUM_CHIPS];
  logic [ADDR_WIDTH-1:0] w_end     [NUM_CHIPS];
  logic [NUM_CHIPS-1:0]  w_rule_hit;
  logic [NUM_CHIPS-1:0]  w_unused_idx;
  logic [NUM_CHIPS-1:0]  w_cs;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_mask;
  entry_t                w_entry;
  logic                  w_push;
  logic                  w_pop;

  entry_t                r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  // Empty ranges (start >= end) fall out of the compare naturally.
  for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_rule
    assign w_start[gi]      = ADDR_WIDTH'(chip_rules_i[gi].start_addr);
    assign w_end[gi]        = ADDR_WIDTH'(chip_rules_i[gi].end_addr);
    assign w_rule_hit[gi]   = (in_addr_i >= w_start[gi]) && (in_addr_i < w_end[gi]);
    assign w_unused_idx[gi] = ^chip_rules_i[gi].idx;
  end

  always_comb begin
    w_cs   = '0;
    w_base = '0;
    w_hit  = 1'b0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (!w_hit && w_rule_hit[i]) begin
        w_hit   = 1'b1;
        w_cs[i] = 1'b1;
        w_base  = w_start[i];
      end
    end
  end

  always_comb begin
    w_mask = '1;
    if (int'(addr_mask_msb_i) < int'(ADDR_WIDTH) - 1) begin
      w_mask = {ADDR_WIDTH{1'b1}} >> (int'(ADDR_WIDTH) - 1 - int'(addr_mask_msb_i));
    end
  end

  always_comb begin
    w_entry.cs     = w_cs;
    w_entry.addr   = (in_addr_i - w_base) & w_mask;
    w_entry.write  = in_write_i;
    w_entry.len    = in_len_i;
    w_entry.decerr = !w_hit;
  end

  assign in_ready_o     = (r_count < 2'd2);
  assign out_valid_o    = (r_count != 2'd0);
  assign w_push         = in_valid_i && in_ready_o;
  assign w_pop          = out_valid_o && out_ready_i;
  assign trans_active_o = (r_count != 2'd0) || phy_busy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= !r_wr_ptr;
      if (w_pop)  r_rd_ptr <= !r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is carried by r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end else if (w_push && w_entry.decerr && (r_err_cnt != c_err_max)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_cs_o     = r_mem[r_rd_ptr].cs;
  assign out_addr_o   = r_mem[r_rd_ptr].addr;
  assign out_write_o  = r_mem[r_rd_ptr].write;
  assign out_len_o    = r_mem[r_rd_ptr].len;
  assign out_decerr_o = r_mem[r_rd_ptr].decerr;
  assign err_cnt_o    = r_err_cnt;

endmodule
`default_nettype wire
